interval_arbiter: RTL and testbench

- Round-robin scheduler that shares one 8-bit interval counter between NUM_REQ requesters.
- Each requester asks for an interval of a given length. The block grants the counter to one requester at a time, counts the interval down and pulses that requester's done bit.
- Sits between the requester logic and the counter datapath. Exposes count for MyHDL co-simulation through its DUT wrapper.

---
 rtl/interval_arbiter_if.sv | 29 ++
 rtl/interval_arbiter.sv | 138 +++++++++++++
 tb/tb_interval_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/interval_arbiter_if.sv
// Bundles the requester-side signals of interval_arbiter.
//   req      requester -> arbiter   per-requester request level
//   req_len  requester -> arbiter   packed lengths, requester i at [i*LEN_W +: LEN_W]
//   gnt      arbiter -> requester   one-hot grant, held for the whole interval
//   done     arbiter -> requester   one-cycle completion pulse
//   busy     arbiter -> requester   high while an interval runs or in the gap after it
//   count    arbiter -> requester   remaining count of the current interval
// master: requester side. slave: arbiter side.
interface interval_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int LEN_W   = 8
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*LEN_W-1:0] req_len;
   logic [NUM_REQ-1:0]       gnt;
   logic [NUM_REQ-1:0]       done;
   logic                     busy;
   logic [LEN_W-1:0]         count;

   modport master (
      output req, req_len,
      input  gnt, done, busy, count
   );

   modport slave (
      input  req, req_len,
      output gnt, done, busy, count
   );
endinterface

// File: rtl/interval_arbiter.sv
// interval_arbiter: round-robin scheduler sharing one down-counter between
// NUM_REQ requesters. A winner gets the counter for len+1 RUN cycles, then a
// one-cycle GAP carries its done pulse, then the arbiter returns to IDLE.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    interval_arbiter_if.slave (req, req_len in; gnt, done, busy, count out)
// Optional build macro INTERVAL_ABORT_EN: dropping req[winner] during RUN
// aborts the interval (GAP without done pulse, pointer still advances).
//
// state | meaning
// IDLE  | no interval active; round-robin pick on any request
// RUN   | counter owned by winner, gnt held, count decrements to 0
// GAP   | one cycle after an interval; done pulse (unless aborted), busy high
module interval_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int LEN_W   = 8
) (
   input logic                clk,
   input logic                reset,
   interval_arbiter_if.slave  bus
);
   localparam int PTR_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               busy_q, busy_d;
   logic [LEN_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   win_q, win_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   ptr_next;

   logic               pick_valid;
   logic [PTR_W-1:0]   pick_idx;

   // First requester at or above ptr_q, wrapping around.
   always_comb begin
      int j;
      logic [PTR_W-1:0] idx;
      j          = 0;
      idx        = '0;
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(ptr_q) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         idx = PTR_W'(j);
         if (!pick_valid && bus.req[idx]) begin
            pick_valid = 1'b1;
            pick_idx   = idx;
         end
      end
   end

   assign ptr_next = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      busy_d  = busy_q;
      count_d = count_q;
      win_d   = win_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            count_d = '0;
            if (pick_valid) begin
               state_d = RUN;
               gnt_d   = NUM_REQ'(1) << pick_idx;
               count_d = bus.req_len[pick_idx*LEN_W +: LEN_W];
               busy_d  = 1'b1;
               win_d   = pick_idx;
            end
         end
         RUN: begin
`ifdef INTERVAL_ABORT_EN
            if (!bus.req[win_q]) begin
               state_d = GAP;
               gnt_d   = '0;
               count_d = '0;
               ptr_d   = ptr_next;
            end else
`endif
            if (count_q == '0) begin
               state_d = GAP;
               gnt_d   = '0;
               done_d  = NUM_REQ'(1) << win_q;
               ptr_d   = ptr_next;
            end else begin
               count_d = count_q - LEN_W'(1);
            end
         end
         GAP: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            count_d = '0;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         count_q <= '0;
         win_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         count_q <= count_d;
         win_q   <= win_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.gnt   = gnt_q;
   assign bus.done  = done_q;
   assign bus.busy  = busy_q;
   assign bus.count = count_q;
endmodule

// File: tb/tb_interval_arbiter.sv
module tb_interval_arbiter;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   interval_arbiter_if #(.NUM_REQ(4), .LEN_W(8)) bus ();

   interval_arbiter #(.NUM_REQ(4), .LEN_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      bus.req     = '0;
      bus.req_len = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
      n_checks++; if (bus.done !== 4'b0000) begin n_fail++; $display("FAIL reset_done: got %b want 0000", bus.done); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_checks++; if (bus.count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
   endtask

   task automatic test_single();
      logic [7:0] exp_cnt [4];
      exp_cnt = '{8'd3, 8'd2, 8'd1, 8'd0};
      do_reset();
      bus.req_len[7:0] = 8'd3;
      bus.req          = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++; if (bus.gnt !== 4'b0001 || bus.count !== exp_cnt[i] || bus.busy !== 1'b1 || bus.done !== 4'b0000) begin
            n_fail++; $display("FAIL single_run%0d: gnt=%b count=%0d busy=%b done=%b want gnt=0001 count=%0d busy=1 done=0000",
                               i, bus.gnt, bus.count, bus.busy, bus.done, exp_cnt[i]);
         end
      end
      step();
      n_checks++; if (bus.done !== 4'b0001 || bus.gnt !== 4'b0000 || bus.busy !== 1'b1 || bus.count !== 8'd0) begin
         n_fail++; $display("FAIL single_gap: done=%b gnt=%b busy=%b count=%0d want done=0001 gnt=0000 busy=1 count=0",
                            bus.done, bus.gnt, bus.busy, bus.count);
      end
      bus.req = 4'b0000;
      step();
      n_checks++; if (bus.done !== 4'b0000 || bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
         n_fail++; $display("FAIL single_idle: done=%b busy=%b gnt=%b want 0000/0/0000", bus.done, bus.busy, bus.gnt);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g;
      do_reset();
      bus.req_len = '0;
      bus.req     = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         exp_g = 4'b0001 << (i % 4);
         step();
         n_checks++; if (bus.gnt !== exp_g || bus.done !== 4'b0000 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL rr_grant%0d: gnt=%b done=%b busy=%b want gnt=%b done=0000 busy=1", i, bus.gnt, bus.done, bus.busy, exp_g);
         end
         step();
         n_checks++; if (bus.done !== exp_g || bus.gnt !== 4'b0000) begin
            n_fail++; $display("FAIL rr_done%0d: done=%b gnt=%b want done=%b gnt=0000", i, bus.done, bus.gnt, exp_g);
         end
         step();
         n_checks++; if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000 || bus.done !== 4'b0000) begin
            n_fail++; $display("FAIL rr_idle%0d: busy=%b gnt=%b done=%b want 0/0000/0000", i, bus.busy, bus.gnt, bus.done);
         end
      end
      bus.req = 4'b0000;
      step();
   endtask

   task automatic test_pointer();
      do_reset();
      bus.req_len = '0;
      bus.req     = 4'b0010;
      step();
      n_checks++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL ptr_first: gnt=%b want 0010", bus.gnt); end
      step();
      bus.req = 4'b0011;
      step();
      step();
      n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL ptr_wrap: gnt=%b want 0001", bus.gnt); end
      step();
      step();
      step();
      n_checks++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL ptr_next: gnt=%b want 0010", bus.gnt); end
      bus.req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_max_len();
      int         n_run;
      logic [7:0] last_cnt;
      do_reset();
      bus.req_len[31:24] = 8'd255;
      bus.req            = 4'b1000;
      step();
      n_checks++; if (bus.gnt !== 4'b1000 || bus.count !== 8'd255) begin
         n_fail++; $display("FAIL max_start: gnt=%b count=%0d want 1000/255", bus.gnt, bus.count);
      end
      n_run    = 1;
      last_cnt = bus.count;
      for (int i = 0; i < 300; i++) begin
         step();
         if (bus.gnt !== 4'b1000) break;
         n_run++;
         last_cnt = bus.count;
      end
      n_checks++; if (n_run != 256) begin n_fail++; $display("FAIL max_runlen: got %0d cycles want 256", n_run); end
      n_checks++; if (last_cnt !== 8'd0) begin n_fail++; $display("FAIL max_lastcnt: got %0d want 0", last_cnt); end
      n_checks++; if (bus.done !== 4'b1000 || bus.count !== 8'd0) begin
         n_fail++; $display("FAIL max_done: done=%b count=%0d want 1000/0", bus.done, bus.count);
      end
      bus.req = 4'b0000;
      step();
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.req_len = '0;
      bus.req     = 4'b0010;
      step();
      step();
      bus.req            = 4'b0100;
      bus.req_len[23:16] = 8'd9;
      step();
      step();
      n_checks++; if (bus.gnt !== 4'b0100 || bus.count !== 8'd9) begin
         n_fail++; $display("FAIL mid_grant: gnt=%b count=%0d want 0100/9", bus.gnt, bus.count);
      end
      for (int i = 0; i < 4; i++) step();
      n_checks++; if (bus.count !== 8'd5) begin n_fail++; $display("FAIL mid_count5: got %0d want 5", bus.count); end
      reset = 1'b1;
      step();
      n_checks++; if (bus.gnt !== 4'b0000 || bus.count !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 4'b0000) begin
         n_fail++; $display("FAIL mid_abort: gnt=%b count=%0d busy=%b done=%b want 0000/0/0/0000", bus.gnt, bus.count, bus.busy, bus.done);
      end
      reset   = 1'b0;
      bus.req = 4'b0110;
      step();
      n_checks++; if (bus.gnt !== 4'b0010 || bus.done !== 4'b0000) begin
         n_fail++; $display("FAIL mid_ptr: gnt=%b done=%b want 0010/0000", bus.gnt, bus.done);
      end
      bus.req = 4'b0010;
      step();
      step();
      bus.req = 4'b0000;
      step();
   endtask

   task automatic test_abort();
      bit seen_done;
      do_reset();
      bus.req_len[23:16] = 8'd10;
      bus.req            = 4'b0100;
      step();
      n_checks++; if (bus.gnt !== 4'b0100 || bus.count !== 8'd10) begin
         n_fail++; $display("FAIL abort_grant: gnt=%b count=%0d want 0100/10", bus.gnt, bus.count);
      end
      for (int i = 0; i < 4; i++) step();
      n_checks++; if (bus.count !== 8'd6) begin n_fail++; $display("FAIL abort_count6: got %0d want 6", bus.count); end
      bus.req = 4'b0000;
      step();
`ifdef INTERVAL_ABORT_EN
      n_checks++; if (bus.gnt !== 4'b0000 || bus.count !== 8'd0 || bus.done !== 4'b0000 || bus.busy !== 1'b1) begin
         n_fail++; $display("FAIL abort_gap: gnt=%b count=%0d done=%b busy=%b want 0000/0/0000/1", bus.gnt, bus.count, bus.done, bus.busy);
      end
      seen_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.done !== 4'b0000) seen_done = 1'b1;
      end
      n_checks++; if (seen_done) begin n_fail++; $display("FAIL abort_nodone: done pulse seen, want none"); end
`else
      n_checks++; if (bus.gnt !== 4'b0100 || bus.count !== 8'd5) begin
         n_fail++; $display("FAIL noabort_hold: gnt=%b count=%0d want 0100/5", bus.gnt, bus.count);
      end
      seen_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.done !== 4'b0000) begin
            seen_done = 1'b1;
            n_checks++; if (bus.done !== 4'b0100 || bus.count !== 8'd0 || i != 5) begin
               n_fail++; $display("FAIL noabort_done: done=%b count=%0d at step %0d want 0100/0 at step 5", bus.done, bus.count, i);
            end
            break;
         end
      end
      n_checks++; if (!seen_done) begin n_fail++; $display("FAIL noabort_timeout: no done pulse within 20 cycles"); end
`endif
      step();
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      reset       = 1'b1;
      bus.req     = '0;
      bus.req_len = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_pointer();
      test_max_len();
      test_reset_mid();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
